// File: rtl/activation_functions_if.sv
// activation_functions_if
//   Command / result bundle for the activation unit.
//   master : command issuer (drives valid_in, addresses, dimensions, opcode)
//   slave  : activation unit (drives result_out, valid_out)
// Ports (signals):
//   valid_in     command strobe
//   input_addr   first source word
//   output_addr  first destination word
//   dimensions   element count, 0..15
//   opcode       7'h4A sigmoid, 7'h4B tanh
//   result_out   latest computed result, Q16.16
//   valid_out    one-cycle pulse when result_out is new
interface activation_functions_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 4
);
  logic                  valid_in;
  logic [ADDR_WIDTH-1:0] input_addr;
  logic [ADDR_WIDTH-1:0] output_addr;
  logic [DIM_WIDTH-1:0]  dimensions;
  logic [6:0]            opcode;
  logic [DATA_WIDTH-1:0] result_out;
  logic                  valid_out;

  modport master (
    output valid_in, input_addr, output_addr, dimensions, opcode,
    input  result_out, valid_out
  );

  modport slave (
    input  valid_in, input_addr, output_addr, dimensions, opcode,
    output result_out, valid_out
  );
endinterface

// File: rtl/activation_functions.sv
// activation_functions
//   Fixed-point (Q16.16) vector activation unit. A command reads `dimensions`
//   consecutive scratchpad words from input_addr, applies a piecewise-linear
//   sigmoid (opcode 7'h4A) or tanh (opcode 7'h4B), writes each result back
//   starting at output_addr and streams it on result_out with a valid_out pulse.
//   One result every two cycles; no backpressure; commands ignored while busy.
// Configuration macro:
//   ACT_TANH_EN  defined   : 7'h4B computes tanh(x) = 2*sig(2x) - 1
//                undefined : tanh logic removed, 7'h4B is an invalid opcode
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset (aborts any command, reloads ramp)
//   bus   activation_functions_if.slave command/result bundle
//
// state | meaning
// IDLE  | waiting for a valid command
// READ  | fetch x from mem[src]
// CALC  | publish y, write mem[dst], advance pointers, count down
module activation_functions #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,  // only 32 is supported
  parameter int DIM_WIDTH  = 4,
  parameter int MEM_DEPTH  = 64   // power of two, <= 2**ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  activation_functions_if.slave bus
);

  localparam int          AW     = $clog2(MEM_DEPTH);
  localparam logic [6:0]  OP_SIG = 7'h4A;
`ifdef ACT_TANH_EN
  localparam logic [6:0]  OP_TANH = 7'h4B;
`endif
  localparam logic [31:0] ONE    = 32'h0001_0000;

  typedef enum logic [1:0] {IDLE, READ, CALC} state_e;

  state_e               state_q;
  logic [AW-1:0]        src_q;
  logic [AW-1:0]        dst_q;
  logic [DIM_WIDTH-1:0] cnt_q;
  logic [31:0]          x_q;
  logic [31:0]          result_q;
  logic                 valid_q;
  logic [31:0]          mem_q [MEM_DEPTH];
`ifdef ACT_TANH_EN
  logic                 tanh_q;
`endif

  logic [31:0] y_d;
  logic        cmd_ok;

  // PLAN sigmoid. |x| is non-negative, so the plain right shifts below are
  // the arithmetic shifts of the magnitude. The most negative input has no
  // positive twin and is clamped to the largest positive magnitude.
  function automatic logic [31:0] sig_f(input logic [31:0] x);
    logic [31:0] a;
    logic [31:0] s;
    if (x == 32'h8000_0000)   a = 32'h7FFF_FFFF;
    else if (x[31])           a = -x;
    else                      a = x;
    if (a >= 32'h0005_0000)      s = ONE;
    else if (a >= 32'h0002_6000) s = (a >> 5) + 32'h0000_D800;
    else if (a >= ONE)           s = (a >> 3) + 32'h0000_A000;
    else                         s = (a >> 2) + 32'h0000_8000;
    return x[31] ? (ONE - s) : s;
  endfunction

`ifdef ACT_TANH_EN
  // 2x saturates: overflow exactly when the top two bits differ.
  function automatic logic [31:0] tanh_f(input logic [31:0] x);
    logic [31:0] x2;
    logic [31:0] s;
    if (x[31] != x[30]) x2 = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else                x2 = {x[30:0], 1'b0};
    s = sig_f(x2);
    return {s[30:0], 1'b0} - ONE;
  endfunction
`endif

  always_comb begin
    cmd_ok = 1'b0;
    if (bus.valid_in && (bus.dimensions != '0)) begin
      if (bus.opcode == OP_SIG) cmd_ok = 1'b1;
`ifdef ACT_TANH_EN
      if (bus.opcode == OP_TANH) cmd_ok = 1'b1;
`endif
    end
  end

  always_comb begin
    y_d = sig_f(x_q);
`ifdef ACT_TANH_EN
    if (tanh_q) y_d = tanh_f(x_q);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
`ifdef ACT_TANH_EN
      tanh_q   <= 1'b0;
`endif
      // Ramp of quarter steps centred on zero: word i = (i - DEPTH/2) * 0.25.
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 32'(i - MEM_DEPTH / 2) << 14;
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_ok) begin
            src_q   <= bus.input_addr[AW-1:0];
            dst_q   <= bus.output_addr[AW-1:0];
            cnt_q   <= bus.dimensions;
`ifdef ACT_TANH_EN
            tanh_q  <= (bus.opcode == OP_TANH);
`endif
            state_q <= READ;
          end
        end
        READ: begin
          x_q     <= mem_q[src_q];
          state_q <= CALC;
        end
        CALC: begin
          result_q     <= y_d;
          valid_q      <= 1'b1;
          // Write lands one edge before the next read, so src == dst chains safely.
          mem_q[dst_q] <= y_d;
          src_q        <= src_q + AW'(1);
          dst_q        <= dst_q + AW'(1);
          cnt_q        <= cnt_q - DIM_WIDTH'(1);
          state_q      <= (cnt_q == DIM_WIDTH'(1)) ? IDLE : READ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result_out = result_q;
  assign bus.valid_out  = valid_q;

  // Address bits above the scratchpad size are intentionally ignored (wrap).
  if (ADDR_WIDTH > AW) begin : g_addr_wrap
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.input_addr[ADDR_WIDTH-1:AW],
                                bus.output_addr[ADDR_WIDTH-1:AW]};
  end

endmodule

// File: tb/tb_activation_functions.sv
`timescale 1ns/1ps
module tb_activation_functions;
  localparam int DEPTH = 64;
`ifdef ACT_TANH_EN
  localparam bit TANH_ON = 1'b1;
`else
  localparam bit TANH_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  activation_functions_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DIM_WIDTH(4)) bus ();

  activation_functions #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .DIM_WIDTH(4), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_m;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic on real-valued magnitudes.
  function automatic logic [31:0] ref_sig(input logic [31:0] w);
    longint x, a, s;
    x = longint'($signed(w));
    a = (x < 0) ? -x : x;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (a >= 5 * 65536)        s = 65536;
    else if (a >= 155648)      s = a / 32 + 55296;   // 2.375, 0.84375
    else if (a >= 65536)       s = a / 8 + 40960;    // 1.0, 0.625
    else                       s = a / 4 + 32768;    // 0.5
    if (x < 0) s = 65536 - s;
    return 32'(s);
  endfunction

  function automatic logic [31:0] ref_tanh(input logic [31:0] w);
    longint x2;
    x2 = 2 * longint'($signed(w));
    if (x2 > 64'sd2147483647)  x2 = 64'sd2147483647;
    if (x2 < -64'sd2147483648) x2 = -64'sd2147483648;
    return 32'(2 * longint'(ref_sig(32'(x2))) - 65536);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'((i - DEPTH / 2) * 16384);
    last_m = 32'h0;
  endtask

  // Issue one command and check every cycle until the unit is idle again.
  task automatic run_cmd(input string name, input logic [6:0] op,
                         input logic [11:0] ia, input logic [11:0] oa,
                         input logic [3:0] dims, input bit inject);
    logic [31:0] exp_q[$];
    bit ok;
    int ncyc;
    ok = (dims != 0) && ((op == 7'h4A) || (TANH_ON && (op == 7'h4B)));
    if (ok) begin
      for (int k = 0; k < int'(dims); k++) begin
        logic [31:0] x, y;
        x = mem_m[(int'(ia) + k) % DEPTH];
        y = (op == 7'h4B) ? ref_tanh(x) : ref_sig(x);
        mem_m[(int'(oa) + k) % DEPTH] = y;
        exp_q.push_back(y);
      end
    end
    @(negedge clk);
    bus.valid_in    = 1'b1;
    bus.opcode      = op;
    bus.input_addr  = ia;
    bus.output_addr = oa;
    bus.dimensions  = dims;
    @(posedge clk);
    @(negedge clk);
    ncyc = ok ? 2 * int'(dims) + 2 : 10;
    for (int c = 1; c <= ncyc; c++) begin
      if (inject && ok && c == 1) begin
        bus.valid_in    = 1'b1;
        bus.opcode      = 7'h4A;
        bus.input_addr  = 12'($urandom);
        bus.output_addr = 12'($urandom);
        bus.dimensions  = 4'd15;
      end else begin
        bus.valid_in = 1'b0;
      end
      @(posedge clk);
      #1;
      if (ok && (c % 2 == 0) && (c / 2 <= int'(dims))) begin
        check($sformatf("%s valid e%0d", name, c / 2 - 1), {31'b0, bus.valid_out}, 32'd1);
        check($sformatf("%s result e%0d", name, c / 2 - 1), bus.result_out, exp_q[c / 2 - 1]);
        last_m = exp_q[c / 2 - 1];
      end else begin
        check($sformatf("%s no_pulse c%0d", name, c), {31'b0, bus.valid_out}, 32'd0);
        check($sformatf("%s hold c%0d", name, c), bus.result_out, last_m);
      end
      @(negedge clk);
    end
  endtask

  task automatic scan_mem(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("%s mem[%0d]", name, i), dut.mem_q[i], mem_m[i]);
    end
  endtask

  initial begin
    logic [6:0]  op;
    logic [3:0]  dims;
    bus.valid_in    = 1'b0;
    bus.opcode      = 7'h0;
    bus.input_addr  = 12'h0;
    bus.output_addr = 12'h0;
    bus.dimensions  = 4'h0;
    model_reset();

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result_out", bus.result_out, 32'h0);
    check("reset valid_out", {31'b0, bus.valid_out}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_cmd("sig_1p0",  7'h4A, 12'h024, 12'h010, 4'd1, 1'b0);
    run_cmd("sig4_neg", 7'h4A, 12'h001, 12'h010, 4'd4, 1'b0);
    run_cmd("tanh3",    7'h4B, 12'h020, 12'h020, 4'd3, 1'b0);
    run_cmd("tanh_wrap", 7'h4B, 12'h042, 12'h030, 4'd2, 1'b0);
    run_cmd("bad_op",   7'h00, 12'h010, 12'h000, 4'd5, 1'b0);
    run_cmd("zero_len", 7'h4A, 12'h010, 12'h000, 4'd0, 1'b0);
    run_cmd("busy_sat", 7'h4A, 12'h03F, 12'h03E, 4'd2, 1'b1);
    run_cmd("chain",    7'h4A, 12'h020, 12'h020, 4'd3, 1'b0);

    repeat (25) begin
      case ($urandom_range(0, 3))
        0, 1:    op = 7'h4A;
        2:       op = 7'h4B;
        default: op = 7'($urandom);
      endcase
      dims = 4'($urandom_range(0, 15));
      run_cmd("rand", op, 12'($urandom), 12'($urandom), dims, 1'($urandom));
    end

    scan_mem("after_cmds");

    // Abort a long command with an asynchronous reset between edges.
    @(negedge clk);
    bus.valid_in    = 1'b1;
    bus.opcode      = 7'h4A;
    bus.input_addr  = 12'h024;
    bus.output_addr = 12'h000;
    bus.dimensions  = 4'd8;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst result_out", bus.result_out, 32'h0);
    check("midrst valid_out", {31'b0, bus.valid_out}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrst quiet c%0d", c), {31'b0, bus.valid_out}, 32'h0);
      check($sformatf("midrst hold c%0d", c), bus.result_out, 32'h0);
    end
    scan_mem("after_rst");

    run_cmd("post_rst", 7'h4A, 12'h03F, 12'h03F, 4'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/activation_functions.md
# activation_functions

Fixed-point vector activation unit for the accelerator datapath. On a command it reads `dimensions` consecutive Q16.16 words from an internal scratchpad starting at `input_addr` and applies a piecewise-linear sigmoid (opcode 0x4A) or tanh (opcode 0x4B) to each word. Each result is written back to the scratchpad starting at `output_addr` and also streamed on `result_out` with a `valid_out` pulse. The in-place write-back lets activation steps chain onto other vector operations.

## Interface
- `ADDR_WIDTH`, default 12: width of the command address fields.
- `DATA_WIDTH`, default 32: word width, Q16.16 two's complement. Only 32 is supported.
- `DIM_WIDTH`, default 4: width of the element count.
- `MEM_DEPTH`, default 64: number of scratchpad words. Must be a power of two and no greater than 2^ADDR_WIDTH.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `valid_in` in 1: command strobe.
- `input_addr` in ADDR_WIDTH: first source word.
- `output_addr` in ADDR_WIDTH: first destination word.
- `dimensions` in DIM_WIDTH: element count, 0–15.
- `opcode` in 7: 0x4A = sigmoid, 0x4B = tanh; all other values are invalid.
- `result_out` out DATA_WIDTH: latest computed result.
- `valid_out` out 1: one-cycle pulse, asserted when `result_out` carries a new result.

## Operation
- **Scratchpad:** MEM_DEPTH × 32 register array.
  - On reset, word i is loaded with (i − MEM_DEPTH/2) << 14. With the default depth this is a ramp from −8.0 to +7.75 in steps of 0.25.
- **Address wrap:** addresses use only the low log2(MEM_DEPTH) bits. Pointers wrap modulo MEM_DEPTH.
- **FSM states:** IDLE, READ, CALC.
  - **IDLE → READ:** when `valid_in` = 1, the opcode is valid, and `dimensions` ≠ 0. On this transition the unit latches the source pointer, destination pointer, count and function.
  - **Ignored commands:** an invalid opcode or `dimensions` = 0 is ignored; the FSM stays in IDLE and outputs are unchanged.
  - **READ:** x ← mem[src]; go to CALC.
  - **CALC:**
    - Register y into `result_out` and pulse `valid_out`.
    - Write mem[dst] ← y.
    - Increment src and dst, and decrement the count.
    - If the count reaches 0, go to IDLE; otherwise go to READ.
- **Busy behaviour:** `valid_in` is ignored while not in IDLE. There is no backpressure.
- **Sigmoid (PLAN approximation):** let a = |x|.
  - a ≥ 5.0 (0x50000): s = 1.0 (0x10000).
  - 2.375 ≤ a < 5.0 (threshold 0x26000): s = a/32 + 0.84375 (0xD800).
  - 1.0 ≤ a < 2.375: s = a/8 + 0.625 (0xA000).
  - a < 1.0: s = a/4 + 0.5 (0x8000).
  - For x < 0, the result is 1.0 − s.
  - Use arithmetic shifts only; no multipliers.
- **Tanh:** tanh(x) = 2·sig(2x) − 1.0.
  - The doubling 2x saturates to 0x7FFFFFFF or 0x80000000 instead of overflowing.
- **Edge case:** x = 0x80000000 uses a = 0x7FFFFFFF.

## Timing
- **Reset:** `result_out` = 0, `valid_out` = 0, state = IDLE, scratchpad = ramp.
  - Reset mid-command aborts the command.
- **Acceptance:** a command is accepted at rising edge E0.
  - Element k's result appears, with `valid_out` high, after edge E0 + 2(k+1).
  - Throughput is one result per 2 cycles.
  - After the last result, the FSM is back in IDLE and can accept a new command on the next edge.
- **In-place operation:** the write for element k happens at the same edge as its result. The read for element k+1 happens one edge later, so in-place (src = dst) and overlapping operation is well defined.
- **Holding:** `result_out` holds its value between pulses.

## Configuration
- `ACT_TANH_EN`:
  - Defined: opcode 0x4B performs tanh as above.
  - Undefined: the tanh and saturating-doubling logic is removed, and 0x4B is treated as an invalid opcode (command ignored, no `valid_out`).

## Test plan
- **Reset:** hold `rst` = 0 → `result_out` = 0, `valid_out` = 0. Release, then issue opcode 0x4A, input_addr 0x024, output_addr 0x010, dims 1 → after 2 edges `result_out` = 0x0000C000 (sig(1.0) = 0.75) with a one-cycle `valid_out`.
- **Sigmoid, 4 elements:** opcode 0x4A, input_addr 0x001, output_addr 0x010, dims 4 → x = −7.75, −7.5, −7.25, −7.0 → four pulses 2 cycles apart, each `result_out` = 0x00000000; mem[0x10..0x13] = 0.
- **Tanh:** opcode 0x4B, input_addr 0x020, dims 3 → x = 0, 0.25, 0.5 → outputs 0x00000000, 0x00004000, 0x00008000. Mem[0x022] = 0x8000 (tanh 0.5) also checked by the above. Address 0x042 wraps to word 2.
- **Invalid opcode / zero length:** opcode 0x00, or `dimensions` = 0 → no `valid_out` for 10 cycles; `result_out` unchanged.
- **Busy and saturation:** while busy, apply `valid_in` with a new command → ignored. Sigmoid of word 0x3F (+7.75) → 0x00010000.
- **Reset mid-command:** assert `rst` mid-command → outputs clear immediately; no further pulses.
